// File: rtl/sonar_ranger.sv
// sonar_ranger: memory-mapped ultrasonic ranger controller (HC-SR04 style).
// Sits on the data-memory bus beside RAM. A write of bit0=1 to CTRL starts a
// measurement: a TRIG_CYCLES-long trigger pulse is emitted, then the width of
// the returning echo pulse is counted in clocks of the synchronized domain.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   wren, addr     bus write enable / word address
//   dataIn         bus write data (CTRL bit0 = start)
//   dataOut        registered read data, 0 when the sampled addr missed
//   hit            combinational decode of CTRL or RESULT address
//   trig           trigger pin to sensor
//   echo           echo pin from sensor (asynchronous)
//   busy           measurement in progress
// Map: BASE_ADDR   CTRL   read {29'b0, timeout, done, busy}
//      BASE_ADDR+1 RESULT read {zero-extended result}, writes ignored
module sonar_ranger #(
  parameter logic [11:0] BASE_ADDR      = 12'hFF0,
  parameter int          TRIG_CYCLES    = 500,
  parameter int          TIMEOUT_CYCLES = 1_500_000,
  parameter int          CNT_W          = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [11:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        hit,
  output logic        trig,
  input  logic        echo,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ECHO, MEASURE} state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]   result, result_nx;
  logic               done, done_nx;
  logic               timeout, timeout_nx;
  logic               sync1, echo_s, echo_q;
  logic               rise, fall, start;
  logic               hit_ctrl, hit_res;
  logic               unused_data;

  // Only bit0 of a CTRL write has a meaning.
  assign unused_data = ^dataIn[31:1];

  assign hit_ctrl = (addr == BASE_ADDR);
  assign hit_res  = (addr == BASE_ADDR + 12'd1);
  assign hit      = hit_ctrl | hit_res;
  assign start    = wren & hit_ctrl & dataIn[0];
  assign busy     = (state != IDLE);

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      echo_s <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      sync1  <= echo;
      echo_s <= sync1;
      echo_q <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_q;
  assign fall = ~echo_s & echo_q;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    result_nx  = result;
    done_nx    = done;
    timeout_nx = timeout;
    case (state)
      IDLE: begin
        // Result is kept from the previous run until it is overwritten.
        if (start) begin
          state_nx   = TRIG;
          cnt_nx     = '0;
          done_nx    = 1'b0;
          timeout_nx = 1'b0;
        end
      end
      TRIG: begin
        if (cnt == TRIG_LAST) begin
          state_nx = WAIT_ECHO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_ECHO: begin
        // A rise on the last waiting cycle still counts as an echo.
        if (rise) begin
          state_nx = MEASURE;
          cnt_nx   = CNT_W'(1);
        end else if (cnt == WAIT_LAST) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
          done_nx    = 1'b1;
          result_nx  = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      MEASURE: begin
        // A fall coinciding with saturation is a clean measurement.
        if (fall) begin
          state_nx  = IDLE;
          result_nx = cnt;
          done_nx   = 1'b1;
        end else if (cnt == MEAS_MAX) begin
          state_nx   = IDLE;
          result_nx  = MEAS_MAX;
          timeout_nx = 1'b1;
          done_nx    = 1'b1;
        end else if (echo_s) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      trig    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      result  <= result_nx;
      done    <= done_nx;
      timeout <= timeout_nx;
      // Registered so the pin cannot glitch on state decode.
      trig    <= (state_nx == TRIG);
    end
  end

  // Read port behaves like RAM: data for the address seen at this edge.
  // Status reflects registers before this edge's update.
  always_ff @(posedge clock) begin
    if (reset)         dataOut <= '0;
    else if (hit_ctrl) dataOut <= {29'b0, timeout, done, busy};
    else if (hit_res)  dataOut <= 32'(result);
    else               dataOut <= '0;
  end

endmodule

// File: tb/tb_sonar_ranger.sv
module tb_sonar_ranger;
  localparam logic [11:0] BASE = 12'hFF0;
  localparam int TRIGC = 4;
  localparam int TOC   = 100;
  localparam int MAXC  = 30000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wren = 1'b0;
  logic [11:0] addr = 12'h000;
  logic [31:0] dataIn = 32'h0;
  logic [31:0] dataOut;
  logic        hit, trig, busy;
  logic        echo = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_on = 0, e_off = 0;

  sonar_ranger #(.BASE_ADDR(BASE), .TRIG_CYCLES(TRIGC), .TIMEOUT_CYCLES(TOC), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .wren(wren), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .hit(hit), .trig(trig), .echo(echo), .busy(busy));

  always #5 clock = ~clock;

  // Echo pin: high for edges e_on .. e_off-1 (edge index = cyc value at that edge).
  always @(negedge clock) echo = (cyc >= e_on) && (cyc < e_off);

  // ---------------- behavioural model ----------------
  // History of the pin and reset as seen at each edge; measurement described
  // by its start edge s and rise edge r, outcomes computed arithmetically.
  bit pin [0:MAXC];
  bit rst [0:MAXC];
  bit          m_busy = 0, m_done = 0, m_to = 0;
  int          m_res = 0;
  int          s = 0, r = -1;

  // Synchronized echo value held after edge m.
  function automatic bit es(int m);
    if (m < 1) return 1'b0;
    if (rst[m] || rst[m-1]) return 1'b0;
    return pin[m-1];
  endfunction

  always @(posedge clock) begin
    int n;
    logic [11:0] a_s;
    bit st, exp_trig, exp_hit;
    logic [31:0] exp_do;
    n = cyc;
    if (n < MAXC) begin
      pin[n] = echo;
      rst[n] = reset;
    end
    a_s = addr;
    st = wren && (addr == BASE) && dataIn[0];
    cyc = cyc + 1;
    #1;
    if (n < MAXC) begin
      if (rst[n]) begin
        m_busy = 0; m_done = 0; m_to = 0; m_res = 0; exp_do = 0;
      end else begin
        if (a_s == BASE)           exp_do = {29'b0, m_to, m_done, m_busy};
        else if (a_s == BASE + 1)  exp_do = 32'(m_res);
        else                       exp_do = 0;
        if (!m_busy) begin
          if (st) begin m_busy = 1; s = n; r = -1; m_done = 0; m_to = 0; end
        end else if (r < 0) begin
          if (n - s >= TRIGC + 1) begin
            if (es(n-1) && !es(n-2)) r = n;
            else if (n - s == TRIGC + TOC) begin
              m_busy = 0; m_to = 1; m_done = 1; m_res = 0;
            end
          end
        end else begin
          if (!es(n-1)) begin
            m_busy = 0; m_done = 1; m_res = n - r;
          end else if (n - r == TOC) begin
            m_busy = 0; m_to = 1; m_done = 1; m_res = TOC;
          end
        end
      end
      exp_trig = m_busy && (r < 0) && (n - s < TRIGC);
      exp_hit  = (a_s == BASE) || (a_s == BASE + 1);
      checks++;
      if (dataOut !== exp_do) begin
        errors++; $display("FAIL dataOut cyc=%0d got %h exp %h", n, dataOut, exp_do);
      end
      checks++;
      if (trig !== exp_trig) begin
        errors++; $display("FAIL trig cyc=%0d got %b exp %b", n, trig, exp_trig);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++; $display("FAIL busy cyc=%0d got %b exp %b", n, busy, m_busy);
      end
      checks++;
      if (hit !== exp_hit) begin
        errors++; $display("FAIL hit cyc=%0d got %b exp %b", n, hit, exp_hit);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1; addr = a; dataIn = d;
    @(negedge clock);
    wren = 1'b0; addr = 12'h000; dataIn = 32'h0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    addr = a;
    @(negedge clock);
    v = dataOut;
    addr = 12'h000;
  endtask

  // Runs until busy drops; counts busy and trig cycles. Optional random bus
  // traffic and a single start poke at a given iteration.
  task automatic wait_idle(input bit rnd, input int poke_at, output int bcnt, output int tcnt);
    bcnt = 0; tcnt = 0;
    while (busy && bcnt < 1000) begin
      bcnt++; tcnt += int'(trig);
      if (bcnt - 1 == poke_at) begin
        wren = 1'b1; addr = BASE; dataIn = 32'h1;
      end else if (rnd) begin
        case ($urandom_range(0, 5))
          0: addr = BASE;
          1: addr = BASE + 12'd1;
          2: begin wren = 1'b1; addr = BASE; dataIn = $urandom; end
          3: begin wren = 1'b1; addr = BASE + 12'd1; dataIn = $urandom; end
          4: begin wren = 1'b1; addr = 12'h010; dataIn = $urandom; end
          default: addr = 12'($urandom_range(0, 4095));
        endcase
      end
      @(negedge clock);
      wren = 1'b0; addr = 12'h000; dataIn = 32'h0;
    end
    checks++;
    if (bcnt >= 1000) begin
      errors++; $display("FAIL wait_idle bound expired got %0d cycles", bcnt);
    end
  endtask

  task automatic echo_quiet();
    while (cyc < e_off + 4) @(negedge clock);
  endtask

  initial begin
    logic [31:0] v;
    int b, t;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // 1: reset state
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    rd(BASE, v);        chk("rst_ctrl", v, 0);
    rd(BASE + 12'd1, v); chk("rst_result", v, 0);

    // 2: normal 37-clock echo, 10 clocks after trig falls
    wr(BASE, 32'h1);
    e_on = cyc + 13; e_off = e_on + 37;
    wait_idle(0, -1, b, t);
    chk("m2_trig_len", 32'(t), 4);
    chk("m2_model_res", 32'(m_res), 37);
    rd(BASE + 12'd1, v); chk("m2_result", v, 37);
    rd(BASE, v);        chk("m2_ctrl", v, 32'h2);
    echo_quiet();

    // 3: no echo -> timeout 104 clocks after start
    wr(BASE, 32'h1);
    wait_idle(0, -1, b, t);
    chk("m3_busy_len", 32'(b), 104);
    rd(BASE, v);        chk("m3_ctrl", v, 32'h6);
    rd(BASE + 12'd1, v); chk("m3_result", v, 0);

    // 4: echo too long -> saturates at 100
    wr(BASE, 32'h1);
    e_on = cyc + 10; e_off = e_on + 200;
    wait_idle(0, -1, b, t);
    chk("m4_model_res", 32'(m_res), 100);
    rd(BASE + 12'd1, v); chk("m4_result", v, 100);
    rd(BASE, v);        chk("m4_ctrl", v, 32'h6);
    echo_quiet();

    // 5: start while busy is ignored
    wr(BASE, 32'h1);
    e_on = cyc + 6; e_off = e_on + 20;
    wait_idle(0, 1, b, t);
    chk("m5_trig_len", 32'(t), 4);
    rd(BASE + 12'd1, v); chk("m5_result", v, 20);
    echo_quiet();

    // 6: reset during MEASURE
    wr(BASE, 32'h1);
    e_on = cyc + 5; e_off = e_on + 50;
    while (cyc < e_on + 20) @(negedge clock);
    chk("m6_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("m6_trig_rst", 32'(trig), 0);
    chk("m6_busy_rst", 32'(busy), 0);
    reset = 1'b0;
    rd(BASE, v);        chk("m6_ctrl", v, 0);
    rd(BASE + 12'd1, v); chk("m6_result", v, 0);
    echo_quiet();
    wr(BASE, 32'h1);
    e_on = cyc + 8; e_off = e_on + 15;
    wait_idle(0, -1, b, t);
    rd(BASE + 12'd1, v); chk("m6_new_result", v, 15);
    echo_quiet();

    // Foreign address write: no hit, no state change
    wren = 1'b1; addr = 12'h010; dataIn = 32'h1;
    #1 chk("foreign_hit", 32'(hit), 0);
    @(negedge clock);
    wren = 1'b0; addr = 12'h000; dataIn = 32'h0;
    chk("foreign_busy", 32'(busy), 0);
    rd(BASE, v); chk("foreign_ctrl", v, 32'h2);

    // Write with bit0 clear does not start
    wr(BASE, 32'hFFFF_FFFE);
    chk("nostart_busy", 32'(busy), 0);

    // Echo already high before the wait window -> stuck-high timeout
    e_on = cyc + 1; e_off = e_on + 200;
    repeat (5) @(negedge clock);
    wr(BASE, 32'h1);
    wait_idle(0, -1, b, t);
    rd(BASE, v);        chk("stuck_ctrl", v, 32'h6);
    rd(BASE + 12'd1, v); chk("stuck_result", v, 0);
    echo_quiet();

    // Randomized measurements with random bus traffic
    for (int i = 0; i < 15; i++) begin
      wr(BASE, 32'h1 | ($urandom & 32'hFFFF_FFFE));
      e_on = cyc + int'($urandom_range(1, 115));
      e_off = e_on + int'($urandom_range(1, 130));
      wait_idle(1, -1, b, t);
      chk("rnd_trig_len", 32'(t), 4);
      echo_quiet();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
